bus_master_arbiter: RTL

- Multi-master arbiter and sequencer for the shared SoC memory bus that feeds the RAM, LED, UART and timer slaves.
- Replaces the fixed two-port instr/data arbitration. It takes N requesters (CPU instr, CPU data, future DMA) and grants them round-robin.
- Holds each grant until the addressed slave acknowledges. A watchdog aborts with an error if the slave never acknowledges.
- Sits between the CPU/DMA ports and the address decoder in top.

---
 rtl/bus_master_arbiter_pkg.sv | 17 +
 rtl/bus_master_arbiter_rr_pick.sv | 30 +++
 rtl/bus_master_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bus_master_arbiter_pkg.sv
// Shared definitions for the round-robin memory-bus master arbiter.
// Combinational helpers only: no latency and no backpressure.
package bus_master_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Width of a master index, kept at least one bit for single-master builds.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_pick.sv
// Round-robin selector: one-hot grant to the first requester after last_grant.
// Purely combinational (zero latency); no backpressure.
module rr_pick
  import bus_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// N-master round-robin bus arbiter with a slave-ack watchdog.
// Latency: request in IDLE drives the slave next cycle; the grant is held until ready_in or timeout.
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MASK_W      = 4,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]        m_read_in,
  input  logic [NUM_MASTERS-1:0]        m_write_in,
  input  logic [NUM_MASTERS*MASK_W-1:0] m_write_mask_in,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_write_value_in,
  output logic [NUM_MASTERS*DATA_W-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]        m_ready_out,
  output logic [NUM_MASTERS-1:0]        m_error_out,
  output logic [ADDR_W-1:0]             address_out,
  output logic                          read_out,
  output logic                          write_out,
  output logic [MASK_W-1:0]             write_mask_out,
  output logic [DATA_W-1:0]             write_value_out,
  input  logic [DATA_W-1:0]             read_value_in,
  input  logic                          ready_in,
  output logic [NUM_MASTERS-1:0]        grant_out
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_MASTERS - 1);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       last_grant;
  logic [CNT_W-1:0]       cnt;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   active;
  logic                   done;
  logic                   rd_done;
  logic                   timed_out;
  logic                   sel_rd;
  logic                   sel_wr;

  logic [ADDR_W-1:0] addr_arr [NUM_MASTERS];
  logic [DATA_W-1:0] wval_arr [NUM_MASTERS];
  logic [MASK_W-1:0] mask_arr [NUM_MASTERS];

  assign req = m_read_in | m_write_in;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Gating with reset keeps every output quiet while reset is held, even mid-access.
  assign active    = (state == ARB_ACCESS) && reset;
  assign done      = active && (ready_in || (cnt == CNT_MAX));
  assign rd_done   = active && ready_in;
  assign timed_out = active && !ready_in && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      grant_q    <= '0;
      last_grant <= LAST_INIT;
      cnt        <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            state      <= ARB_ACCESS;
            grant_q    <= pick;
            last_grant <= pick_idx;
            cnt        <= '0;
          end
        end
        ARB_ACCESS: begin
          if (ready_in || (cnt == CNT_MAX)) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // last_grant doubles as the owner index while in ACCESS.
  assign sel_rd = m_read_in[last_grant];
  assign sel_wr = m_write_in[last_grant];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    assign addr_arr[i] = m_address_in[i*ADDR_W +: ADDR_W];
    assign wval_arr[i] = m_write_value_in[i*DATA_W +: DATA_W];
    assign mask_arr[i] = m_write_mask_in[i*MASK_W +: MASK_W];
    assign m_read_value_out[i*DATA_W +: DATA_W] = (rd_done && grant_q[i]) ? read_value_in : '0;
  end

  assign write_out       = active && sel_wr;
  assign read_out        = active && sel_rd && !sel_wr;
  assign address_out     = active ? addr_arr[last_grant] : '0;
  assign write_value_out = active ? wval_arr[last_grant] : '0;
  assign write_mask_out  = write_out ? mask_arr[last_grant] : '0;

  assign m_ready_out = done      ? grant_q : '0;
  assign m_error_out = timed_out ? grant_q : '0;
  assign grant_out   = reset     ? grant_q : '0;

endmodule
